// File: rtl/rmii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rmii_pkg
//  Description : Shared types and constants for the RMII receive/transmit
//                datapath (FSM state encoding, preamble/SFD dibit values).
//  Revision    : 1.0 - initial release
// ============================================================================
package rmii_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        DROP     = 3'd3,
        FLUSH    = 3'd4
    } rx_state_t;

    localparam logic [1:0] DIBIT_PRE       = 2'b01;
    localparam logic [1:0] DIBIT_SFD       = 2'b11;
    localparam int         DIBITS_PER_BYTE = 4;

endpackage : rmii_pkg
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_sync_fifo
//  Description : Single-clock FIFO with a stream-style read side. The head
//                entry is presented from registered state, so rd_valid_o
//                rises the cycle after the first write.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                wr_en_i/data_i  - write request (honoured only if wr_ready_o)
//                wr_ready_o      - space available (includes same-cycle pop)
//                rd_valid_o      - head entry valid
//                rd_ready_i      - consumer accepts head entry
//                rd_data_o       - head entry (zero while empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_ready_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    logic w_empty;
    logic w_full;
    logic w_rd_fire;
    logic w_wr_fire;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty   = (wptr_q == rptr_q);
    assign w_full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign w_rd_fire = !w_empty && rd_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
    assign wr_ready_o = !w_full || w_rd_fire;
    assign w_wr_fire  = wr_en_i && wr_ready_o;

    assign rd_valid_o = !w_empty;
    assign rd_data_o  = w_empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_wr_fire) begin
                wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (w_rd_fire) begin
                rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule : axis_sync_fifo
`default_nettype wire

// File: rtl/rmii_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : rmii_rx_deser
//  Description : RMII receive deserializer. Reassembles RX_D dibits into
//                bytes (LSB dibit first), optionally strips preamble/SFD,
//                tags frame end (tlast) and malformed frames (tuser), and
//                delivers bytes on an AXI-Stream master through a FIFO.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                RX_D, RX_DV         - RMII receive dibit / data valid
//                m_axis_t*           - AXI-Stream master (data, valid, ready,
//                                      last, user = frame error)
//                overflow_pulse      - byte dropped because FIFO was full
//  Revision    : 1.0 - initial release
// ============================================================================
module rmii_rx_deser
    import rmii_pkg::*;
#(
    parameter int BW         = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SFD_DETECT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    RX_D,
    input  logic          RX_DV,
    output logic [BW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          m_axis_tuser,
    output logic          overflow_pulse
);

    rx_state_t     state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [5:0]    sr_q, sr_d;          // first three dibits of the byte in progress
    logic [BW-1:0] stage_q, stage_d;
    logic          stage_vld_q, stage_vld_d;
    logic          pre_seen_q, pre_seen_d;
    logic          armed_q, armed_d;    // a gap (RX_DV low) has been seen since reset
    logic          ovf_q, ovf_d;

    logic          w_push;
    logic [BW+1:0] w_push_data;
    logic          w_wr_ready;
    logic [BW+1:0] w_rd_data;
    logic [BW-1:0] w_byte;

    assign w_byte = {RX_D, sr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        stage_d     = stage_q;
        stage_vld_d = stage_vld_q;
        pre_seen_d  = pre_seen_q;
        ovf_d       = 1'b0;
        w_push      = 1'b0;
        w_push_data = '0;

        // A frame that starts while flushing is dropped whole: disarm until
        // the line goes idle again.
        armed_d = armed_q;
        if (!RX_DV) begin
            armed_d = 1'b1;
        end else if (state_q == FLUSH) begin
            armed_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                if (RX_DV && armed_q) begin
                    if (SFD_DETECT != 0) begin
                        state_d    = PREAMBLE;
                        pre_seen_d = (RX_D == DIBIT_PRE);
                    end else begin
                        state_d   = DATA;
                        sr_d[1:0] = RX_D;
                        cnt_d     = 2'd1;
                    end
                end
            end

            PREAMBLE: begin
                if (!RX_DV) begin
                    state_d = IDLE;
                end else if (RX_D == DIBIT_PRE) begin
                    pre_seen_d = 1'b1;
                end else if ((RX_D == DIBIT_SFD) && pre_seen_q) begin
                    state_d = DATA;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = DROP;
                end
            end

            DATA: begin
                if (!RX_DV) begin
                    cnt_d = 2'd0;
                    if (stage_vld_q) begin
                        if (w_wr_ready) begin
                            w_push      = 1'b1;
                            w_push_data = {stage_q, 1'b1, (cnt_q != 2'd0)};
                            stage_vld_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            // Keep the final byte; FLUSH delivers it flagged.
                            ovf_d   = 1'b1;
                            state_d = FLUSH;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0:    sr_d[1:0] = RX_D;
                        2'd1:    sr_d[3:2] = RX_D;
                        2'd2:    sr_d[5:4] = RX_D;
                        default: begin
                            if (!stage_vld_q) begin
                                stage_d     = w_byte;
                                stage_vld_d = 1'b1;
                            end else if (w_wr_ready) begin
                                w_push      = 1'b1;
                                w_push_data = {stage_q, 1'b0, 1'b0};
                                stage_d     = w_byte;
                            end else begin
                                // New byte is lost; the staged one closes the frame later.
                                ovf_d   = 1'b1;
                                state_d = DROP;
                            end
                        end
                    endcase
                end
            end

            DROP: begin
                if (!RX_DV) begin
                    state_d = stage_vld_q ? FLUSH : IDLE;
                end
            end

            FLUSH: begin
                if (w_wr_ready) begin
                    w_push      = 1'b1;
                    w_push_data = {stage_q, 1'b1, 1'b1};
                    stage_vld_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            sr_q        <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            pre_seen_q  <= 1'b0;
            armed_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            pre_seen_q  <= pre_seen_d;
            armed_q     <= armed_d;
            ovf_q       <= ovf_d;
        end
    end

    axis_sync_fifo #(
        .WIDTH (BW + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (w_push),
        .wr_data_i  (w_push_data),
        .wr_ready_o (w_wr_ready),
        .rd_valid_o (m_axis_tvalid),
        .rd_ready_i (m_axis_tready),
        .rd_data_o  (w_rd_data)
    );

    assign m_axis_tdata   = w_rd_data[BW+1:2];
    assign m_axis_tlast   = w_rd_data[1];
    assign m_axis_tuser   = w_rd_data[0];
    assign overflow_pulse = ovf_q;

endmodule : rmii_rx_deser
`default_nettype wire
